display_scheduler: RTL and testbench

//  Shares the single 16-bit display data path (4 hex digits into SevenSegmentDisplay.switches)

---
 rtl/display_scheduler.sv | 113 +++++++++++
 tb/tb_display_scheduler.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - fixed-priority owner arbitration for the shared 4-digit display path
// with minimum-hold preemption guard and per-digit blink blanking.
module display_scheduler #(
  parameter int MIN_HOLD  = 50_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [3:0]  blink_mask,
  output logic [1:0]  grant,
  output logic [1:0]  ack,
  output logic [15:0] disp_data,
  output logic [3:0]  digit_blank
);

  localparam int HW = (MIN_HOLD < 2) ? 1 : $clog2(MIN_HOLD + 1);
  localparam int BW = (BLINK_DIV < 2) ? 1 : $clog2(BLINK_DIV);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(MIN_HOLD);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [HW-1:0] hold_cnt;
  logic          hold_done;
  logic [BW-1:0] blink_cnt;
  logic          phase_off;
  logic          changed;
  logic [1:0]    ack_nxt;

  assign hold_done = (hold_cnt == HOLD_MAX);

  // Source 2 is never preempted; source 1 yields to source 2 only once the hold has elapsed.
  always_comb begin
    state_nxt = state;
    case (state)
      S0: begin
        if (req[1])      state_nxt = S2;
        else if (req[0]) state_nxt = S1;
      end
      S1: begin
        if (!req[0])                state_nxt = req[1] ? S2 : S0;
        else if (req[1] && hold_done) state_nxt = S2;
      end
      S2: begin
        if (!req[1]) state_nxt = req[0] ? S1 : S0;
      end
      default: state_nxt = S0;
    endcase
  end

  always_comb begin
    changed    = (state_nxt != state);
    ack_nxt    = 2'b00;
    ack_nxt[0] = changed && (state_nxt == S1);
    ack_nxt[1] = changed && (state_nxt == S2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S0;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           hold_cnt <= '0;
    else if (changed)                   hold_cnt <= '0;
    else if (state != S0 && !hold_done) hold_cnt <= hold_cnt + 1'b1;
  end

  // A new owner restarts the blink in the visible phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      phase_off <= 1'b0;
    end else if (changed) begin
      blink_cnt <= '0;
      phase_off <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase_off <= ~phase_off;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack         <= 2'b00;
      disp_data   <= 16'h0000;
      digit_blank <= 4'b0000;
    end else begin
      ack         <= ack_nxt;
      digit_blank <= blink_mask & {4{phase_off}};
      case (state)
        S1:      disp_data <= data1;
        S2:      disp_data <= data2;
        default: disp_data <= data0;
      endcase
    end
  end

  assign grant = state;

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - scoreboard bench for display_scheduler
// (MIN_HOLD=4, BLINK_DIV=3) with a time-since-ownership reference model.
module tb_display_scheduler;

  localparam int MIN_HOLD  = 4;
  localparam int BLINK_DIV = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] data0, data1, data2;
  logic [3:0]  blink_mask;
  logic [1:0]  grant, ack;
  logic [15:0] disp_data;
  logic [3:0]  digit_blank;

  display_scheduler #(.MIN_HOLD(MIN_HOLD), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .blink_mask(blink_mask),
    .grant(grant), .ack(ack), .disp_data(disp_data), .digit_blank(digit_blank)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  grant;
    logic [1:0]  ack;
    logic [15:0] disp;
    logic [3:0]  blank;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;
  int m_owner;
  int m_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_t     = 0;
    q.delete();
  endtask

  // m_t is the number of edges since the current owner took over (or since reset).
  task automatic tick();
    int   prev;
    int   nxt;
    exp_t e;
    prev = m_owner;
    nxt  = prev;
    if (prev == 0)      nxt = req[1] ? 2 : (req[0] ? 1 : 0);
    else if (prev == 1) begin
      if (!req[0])                         nxt = req[1] ? 2 : 0;
      else if (req[1] && m_t >= MIN_HOLD)  nxt = 2;
    end else if (!req[1]) nxt = req[0] ? 1 : 0;
    e.grant = 2'(nxt);
    e.ack   = {nxt == 2 && prev != 2, nxt == 1 && prev != 1};
    e.disp  = (prev == 0) ? data0 : (prev == 1) ? data1 : data2;
    e.blank = (((m_t / BLINK_DIV) % 2) == 1) ? blink_mask : 4'b0000;
    m_t     = (nxt != prev) ? 0 : m_t + 1;
    m_owner = nxt;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rst && q.size() > 0) begin
      e = q.pop_front();
      check("grant",       32'(grant),       32'(e.grant));
      check("ack",         32'(ack),         32'(e.ack));
      check("disp_data",   32'(disp_data),   32'(e.disp));
      check("digit_blank", 32'(digit_blank), 32'(e.blank));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b0;
    req        = 2'b11;
    data0      = 16'h0000;
    data1      = 16'h0000;
    data2      = 16'h0000;
    blink_mask = 4'b0000;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_ack",   32'(ack),   32'd0);
    check("reset_disp",  32'(disp_data), 32'h0000);
    check("reset_blank", 32'(digit_blank), 32'd0);

    rst = 1'b1;
    tick();
    req = 2'b00;
    ticks(3);

    data0 = 16'h1234; data1 = 16'hA1A5; data2 = 16'h5A5A;
    req = 2'b01;
    ticks(3);
    req = 2'b00;
    ticks(3);

    req = 2'b01;
    tick();
    req = 2'b11;
    ticks(8);
    ticks(4);

    req = 2'b01;
    ticks(3);
    req = 2'b00;
    ticks(2);

    blink_mask = 4'b0011;
    req = 2'b01;
    ticks(12);
    req = 2'b11;
    ticks(10);
    req = 2'b00;
    ticks(2);

    req = 2'b01;
    ticks(5);
    #2;
    rst = 1'b0;
    #1;
    check("async_grant", 32'(grant),       32'd0);
    check("async_ack",   32'(ack),         32'd0);
    check("async_disp",  32'(disp_data),   32'h0000);
    check("async_blank", 32'(digit_blank), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    ticks(4);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 5) == 0) req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) data0 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data1 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data2 = 16'($urandom);
      if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
      tick();
    end

    @(posedge clk);
    #2;
    check("queue_drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
